// File: rtl/instr_fetch_sequencer.sv
// Multi-cycle fetch/issue controller: fetches from a registered-output block RAM,
// loads the IR, issues it with a valid/done handshake, then advances the PC.
module instr_fetch_sequencer #(
  parameter int          ADDR_W  = 11,
  parameter int          DATA_W  = 32,
  parameter int          MEM_LAT = 1,
  parameter logic [4:0]  HLT_OP  = 5'b11111
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_halt_req,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic [DATA_W-1:0] o_ir,
  output logic              o_ir_valid,
  input  logic              i_exec_done,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy,
  output logic              o_halted,
  output logic [15:0]       o_retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [2:0]          r_wait_cnt;
  logic                r_halt_latch;
  logic [15:0]         r_retired;
  logic                w_busy;
  logic                w_is_hlt;

  assign w_is_hlt = (r_ir[DATA_W-1 -: 5] == HLT_OP);
  assign w_busy   = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                    (r_state == S_ISSUE) || (r_state == S_EXEC);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (i_start) w_next = S_FETCH;
      S_FETCH:          w_next = S_WAIT;
      S_WAIT:           if (r_wait_cnt == 3'd0) w_next = S_ISSUE;
      S_ISSUE:          w_next = w_is_hlt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (i_exec_done) begin
          w_next = (r_halt_latch || i_halt_req) ? S_HALTED : S_FETCH;
        end
      end
      default:          w_next = S_IDLE;
    endcase
  end

  // The wait counter runs MEM_LAT cycles so the IR captures the RAM output in the
  // exact cycle it becomes valid after the FETCH-cycle read enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_wait_cnt <= 3'd0;
      r_retired  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (i_start) begin
            r_pc      <= '0;
            r_retired <= 16'd0;
          end
        end
        S_FETCH: r_wait_cnt <= LAT_M1;
        S_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            r_ir <= i_mem_dout;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        S_EXEC: begin
          if (i_exec_done) begin
            r_pc <= r_pc + ADDR_W'(1);
            if (r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A halt request seen anywhere in a busy state is remembered until the next
  // instruction boundary actually drops the sequencer into HALTED.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_halt_latch <= 1'b0;
    end else if (w_next == S_HALTED) begin
      r_halt_latch <= 1'b0;
    end else if (w_busy && i_halt_req) begin
      r_halt_latch <= 1'b1;
    end
  end

  assign o_mem_en   = (r_state == S_FETCH);
  assign o_mem_addr = r_pc;
  assign o_pc       = r_pc;
  assign o_ir       = r_ir;
  assign o_ir_valid = (r_state == S_ISSUE) && !w_is_hlt;
  assign o_busy     = w_busy;
  assign o_halted   = (r_state == S_HALTED);
  assign o_retired  = r_retired;

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Multi-cycle fetch/issue controller for the 32-bit GPR/ALU datapath.
- Reads instructions from the single-port instruction block RAM (blk_mem_gen_0, registered output) at the PC and loads the instruction register (IR).
- Presents each instruction to the execute datapath with a valid/done handshake, then advances the PC.
- Replaces the free-running delay-counter fetch loop with a deterministic FSM that has start, halt and retire counting.

Parameters:
- ADDR_W, 11, instruction memory address width; PC width.
- DATA_W, 32, instruction width (IR format: [31:27] oper_type, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:0] isrc/rsrc2).
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_dout; legal range 1..7.
- HLT_OP, 5'b11111, oper_type value that halts the sequencer. This value is not issued to the datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; sampled in IDLE/HALTED; begins execution at PC 0.
- halt_req  in  1  request to stop at the next instruction boundary.
- mem_en  out  1  memory read enable, one-cycle pulse per fetch.
- mem_addr  out  ADDR_W  memory address; equals pc.
- mem_dout  in  DATA_W  memory read data.
- ir  out  DATA_W  instruction register to the datapath.
- ir_valid  out  1  one-cycle pulse; ir is stable and must be executed.
- exec_done  in  1  datapath has completed the issued instruction.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH/WAIT/ISSUE/EXEC.
- halted  out  1  high in HALTED.
- retired  out  16  count of completed instructions; saturates at 16'hFFFF.

Behaviour:
- Reset values (async, while rst=1):
  - state=IDLE.
  - pc=0, ir=0, mem_en=0, ir_valid=0, busy=0, halted=0, retired=0.
  - halt latch=0, wait counter=0.
  - Reset mid-operation abandons the instruction in flight. No ir_valid is produced after reset deasserts until a new start.
- IDLE:
  - start=1 -> FETCH, with pc<=0 and retired<=0.
- FETCH (1 cycle):
  - mem_en=1, mem_addr=pc.
  - Load wait counter with MEM_LAT-1 -> WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 0: ir<=mem_dout -> ISSUE.
  - For MEM_LAT=1, WAIT lasts exactly 1 cycle.
- ISSUE (1 cycle):
  - If ir[31:27]==HLT_OP: ir_valid stays 0 -> HALTED. pc is unchanged and retired is not incremented.
  - Otherwise: ir_valid=1 -> EXEC.
- EXEC:
  - Hold ir stable and wait for exec_done. exec_done is sampled only in EXEC; it may be asserted in the first EXEC cycle.
  - On exec_done: retired<=retired+1 (saturating) and pc<=pc+1. pc wraps from 2^ADDR_W-1 to 0 with no flag.
  - After exec_done: go to HALTED if the halt latch is set or halt_req=1 in this cycle; otherwise go to FETCH.
- Halt latch:
  - Set by halt_req=1 in any busy state; cleared on entry to HALTED.
  - halt_req is ignored in IDLE/HALTED.
- HALTED:
  - halted=1; pc and retired hold.
  - start=1 -> FETCH with pc<=0 and retired<=0.
- start in busy states is ignored.
- Throughput: minimum 3+MEM_LAT cycles per instruction (FETCH, WAIT×MEM_LAT, ISSUE, EXEC×≥1).
- With MEM_LAT=1 and exec_done tied high:
  - start sampled at edge 0.
  - mem_en high in cycle 1, ir loaded at edge 2, ir_valid high in cycle 3.
  - Next mem_en in cycle 5.
- No combinational path from any input to any output except mem_addr=pc (registered). All outputs are registered or decoded from the state register.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then rst=0 with start=0 for 10 cycles -> state held at IDLE, all outputs 0, no mem_en pulse.
- Straight-line program:
  - Setup: memory words 0..2 = 32'h1100_0004 (ADI), 32'h1100_2800 (ADD), 32'hF800_0000 (HLT); MEM_LAT=1; exec_done tied high.
  - Required: ir_valid pulses exactly twice with ir matching words 0 and 1, 4 cycles apart. Then halted=1, pc=2, retired=2, busy=0.
- Slow datapath: as above, but exec_done asserted 5 cycles after each ir_valid -> ir held stable across EXEC, mem_en not pulsed until the cycle after exec_done, retired increments once per instruction.
- Halt request: pulse halt_req for 1 cycle during WAIT of instruction 0 (program with no HLT) -> instruction 0 still issues and retires, then halted=1, pc=1, retired=1. A subsequent start restarts at pc=0 with retired=0.
- Latency and wrap:
  - Latency: MEM_LAT=3 -> exactly 3 cycles between mem_en and the ir load.
  - Wrap: ADDR_W=3, memory filled with non-HLT instructions, exec_done tied high -> pc counts 0..7 then 0; mem_addr sequence matches.
- Reset mid-operation: assert rst during EXEC (exec_done low) -> outputs return to 0 immediately (asynchronously). After release, no ir_valid is produced until start.
